// File: rtl/prv_trap_sequencer_if.sv
// Signal bundle between hazard unit / interrupt sources / CSR file and the trap sequencer.
// slave modport is the sequencer; master modport is the surrounding pipeline and CSR logic.
interface prv_trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            fault_insn;
  logic            mal_insn;
  logic            illegal_insn;
  logic            fault_l;
  logic            mal_l;
  logic            fault_s;
  logic            mal_s;
  logic            breakpoint;
  logic            env_m;
  logic            ret;
  logic            pipe_clear;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] badaddr;
  logic            timer_int;
  logic            soft_int;
  logic            ext_int;
  logic            mie_mtie;
  logic            mie_msie;
  logic            mie_meie;
  logic            mstatus_mie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  logic [XLEN-1:0] priv_pc;
  logic            insert_pc;
  logic            intr;
  logic            mip_mtip;
  logic            mip_msip;
  logic            mip_meip;
  logic [XLEN-1:0] mcause;
  logic            mcause_we;
  logic            mepc_we;
  logic            mtval_we;
  logic [XLEN-1:0] mepc_wdata;
  logic [XLEN-1:0] mtval_wdata;
  logic            mstatus_trap;
  logic            mstatus_ret;

  modport master (
    output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env_m, ret, pipe_clear, epc, badaddr,
           timer_int, soft_int, ext_int, mie_mtie, mie_msie, mie_meie, mstatus_mie,
           mtvec, mepc,
    input  priv_pc, insert_pc, intr, mip_mtip, mip_msip, mip_meip, mcause,
           mcause_we, mepc_we, mtval_we, mepc_wdata, mtval_wdata,
           mstatus_trap, mstatus_ret
  );

  modport slave (
    input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env_m, ret, pipe_clear, epc, badaddr,
           timer_int, soft_int, ext_int, mie_mtie, mie_msie, mie_meie, mstatus_mie,
           mtvec, mepc,
    output priv_pc, insert_pc, intr, mip_mtip, mip_msip, mip_meip, mcause,
           mcause_we, mepc_we, mtval_we, mepc_wdata, mtval_wdata,
           mstatus_trap, mstatus_ret
  );
endinterface

// File: rtl/prv_trap_sequencer.sv
// Trap/mret sequencer: latch + prioritise event, wait in DRAIN for pipe_clear (unbounded), 1-cycle redirect + CSR strobes.
// Event->insert_pc >= 2 cycles, interrupt source->insert_pc >= 4. PRV_VECTORED_INTR_EN enables vectored interrupt targets.
module prv_trap_sequencer #(
  parameter int XLEN = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  prv_trap_sequencer_if.slave bus_io
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e          state_q;

  logic [3:0]      cause_q;
  logic            is_int_q;
  logic            is_ret_q;
  logic            tval_q;
  logic [XLEN-3:0] epc_q;
  logic [XLEN-1:0] badaddr_q;

  logic            mip_mtip_q;
  logic            mip_msip_q;
  logic            mip_meip_q;
  logic            int_req_q;
  logic [3:0]      int_code_q;

  logic [XLEN-1:0] priv_pc_q;
  logic            insert_pc_q;
  logic            intr_q;
  logic [XLEN-1:0] mcause_q;
  logic            mcause_we_q;
  logic            mepc_we_q;
  logic            mtval_we_q;
  logic [XLEN-1:0] mepc_wdata_q;
  logic [XLEN-1:0] mtval_wdata_q;
  logic            mstatus_trap_q;
  logic            mstatus_ret_q;

  logic            exc_any;
  logic [3:0]      exc_code;
  logic            exc_tval;

  always_comb begin
    exc_any  = 1'b1;
    exc_code = 4'd0;
    exc_tval = 1'b1;
    if (bus_io.fault_insn)        exc_code = 4'd1;
    else if (bus_io.mal_insn)     exc_code = 4'd0;
    else if (bus_io.illegal_insn) exc_code = 4'd2;
    else if (bus_io.breakpoint) begin
      exc_code = 4'd3;
      exc_tval = 1'b0;
    end else if (bus_io.env_m) begin
      exc_code = 4'd11;
      exc_tval = 1'b0;
    end else if (bus_io.mal_l)    exc_code = 4'd4;
    else if (bus_io.mal_s)        exc_code = 4'd6;
    else if (bus_io.fault_l)      exc_code = 4'd5;
    else if (bus_io.fault_s)      exc_code = 4'd7;
    else begin
      exc_any  = 1'b0;
      exc_tval = 1'b0;
    end
  end

  // pend = {MEI, MSI, MTI}; highest index wins
  logic [2:0] pend;
  logic       int_req_d;
  logic [3:0] int_code_d;
  logic       int_take;

  assign pend = {mip_meip_q & bus_io.mie_meie,
                 mip_msip_q & bus_io.mie_msie,
                 mip_mtip_q & bus_io.mie_mtie};
  assign int_req_d  = bus_io.mstatus_mie & (|pend);
  assign int_code_d = pend[2] ? 4'd11 : (pend[1] ? 4'd3 : 4'd7);
  // Requalify with the live enable so a request registered before a trap cleared MIE is not taken.
  assign int_take   = int_req_q & bus_io.mstatus_mie;

  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mcause_val;

  assign trap_base = {bus_io.mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    trap_target = trap_base;
`ifdef PRV_VECTORED_INTR_EN
    if (is_int_q && (bus_io.mtvec[1:0] == 2'b01)) begin
      trap_target = trap_base + {{(XLEN-6){1'b0}}, cause_q, 2'b00};
    end
`endif
  end

  always_comb begin
    mcause_val         = '0;
    mcause_val[XLEN-1] = is_int_q;
    mcause_val[3:0]    = cause_q;
  end

`ifdef PRV_VECTORED_INTR_EN
  logic unused_low_bits;
  assign unused_low_bits = ^{bus_io.epc[1:0], bus_io.mepc[1:0]};
`else
  logic unused_low_bits;
  assign unused_low_bits = ^{bus_io.epc[1:0], bus_io.mepc[1:0], bus_io.mtvec[1:0]};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cause_q        <= 4'd0;
      is_int_q       <= 1'b0;
      is_ret_q       <= 1'b0;
      tval_q         <= 1'b0;
      epc_q          <= '0;
      badaddr_q      <= '0;
      mip_mtip_q     <= 1'b0;
      mip_msip_q     <= 1'b0;
      mip_meip_q     <= 1'b0;
      int_req_q      <= 1'b0;
      int_code_q     <= 4'd0;
      priv_pc_q      <= '0;
      insert_pc_q    <= 1'b0;
      intr_q         <= 1'b0;
      mcause_q       <= '0;
      mcause_we_q    <= 1'b0;
      mepc_we_q      <= 1'b0;
      mtval_we_q     <= 1'b0;
      mepc_wdata_q   <= '0;
      mtval_wdata_q  <= '0;
      mstatus_trap_q <= 1'b0;
      mstatus_ret_q  <= 1'b0;
    end else begin
      mip_mtip_q     <= bus_io.timer_int;
      mip_msip_q     <= bus_io.soft_int;
      mip_meip_q     <= bus_io.ext_int;
      int_req_q      <= int_req_d;
      int_code_q     <= int_code_d;

      insert_pc_q    <= 1'b0;
      mcause_we_q    <= 1'b0;
      mepc_we_q      <= 1'b0;
      mtval_we_q     <= 1'b0;
      mstatus_trap_q <= 1'b0;
      mstatus_ret_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (exc_any) begin
            cause_q   <= exc_code;
            is_int_q  <= 1'b0;
            is_ret_q  <= 1'b0;
            tval_q    <= exc_tval;
            epc_q     <= bus_io.epc[XLEN-1:2];
            badaddr_q <= bus_io.badaddr;
            state_q   <= DRAIN;
          end else if (bus_io.ret) begin
            is_int_q  <= 1'b0;
            is_ret_q  <= 1'b1;
            tval_q    <= 1'b0;
            state_q   <= DRAIN;
          end else if (int_take) begin
            cause_q   <= int_code_q;
            is_int_q  <= 1'b1;
            is_ret_q  <= 1'b0;
            tval_q    <= 1'b0;
            epc_q     <= bus_io.epc[XLEN-1:2];
            intr_q    <= 1'b1;
            state_q   <= DRAIN;
          end
        end

        DRAIN: begin
          if (bus_io.pipe_clear) begin
            state_q     <= REDIRECT;
            insert_pc_q <= 1'b1;
            if (is_ret_q) begin
              priv_pc_q     <= {bus_io.mepc[XLEN-1:2], 2'b00};
              mstatus_ret_q <= 1'b1;
            end else begin
              priv_pc_q      <= trap_target;
              mcause_q       <= mcause_val;
              mcause_we_q    <= 1'b1;
              mepc_we_q      <= 1'b1;
              mtval_we_q     <= tval_q;
              mepc_wdata_q   <= {epc_q, 2'b00};
              mtval_wdata_q  <= badaddr_q;
              mstatus_trap_q <= 1'b1;
            end
          end
        end

        REDIRECT: begin
          state_q  <= IDLE;
          intr_q   <= 1'b0;
          is_ret_q <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.priv_pc      = priv_pc_q;
  assign bus_io.insert_pc    = insert_pc_q;
  assign bus_io.intr         = intr_q;
  assign bus_io.mip_mtip     = mip_mtip_q;
  assign bus_io.mip_msip     = mip_msip_q;
  assign bus_io.mip_meip     = mip_meip_q;
  assign bus_io.mcause       = mcause_q;
  assign bus_io.mcause_we    = mcause_we_q;
  assign bus_io.mepc_we      = mepc_we_q;
  assign bus_io.mtval_we     = mtval_we_q;
  assign bus_io.mepc_wdata   = mepc_wdata_q;
  assign bus_io.mtval_wdata  = mtval_wdata_q;
  assign bus_io.mstatus_trap = mstatus_trap_q;
  assign bus_io.mstatus_ret  = mstatus_ret_q;

endmodule
